pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the IF stage's pcsrc and hazard inputs and the ID/EX pipeline-register stall/flush enables. It detects load-use hazards, sequences taken-branch flushes over a configurable number of cycles, and freezes the pipeline on instruction- or data-memory wait. It also keeps a stall-cycle performance counter and a sticky data-memory timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
//
// Detects load-use hazards, sequences taken-branch flushes over FLUSH_CYCLES
// cycles and freezes the whole pipeline while data memory is busy. Also keeps
// a saturating stall-cycle counter and a sticky data-memory timeout flag.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt
//   ex_memread, ex_rt   EX instruction is a load, and its destination
//   ex_branch_taken     branch in EX resolved taken
//   imem_ready          fetch data valid this cycle
//   dmem_ready          data memory access complete (1 when idle)
//   pcsrc, hazard       IF controls: take branch offset / hold PC
//   stall_id, stall_ex  hold IF/ID, hold ID/EX and EX/MEM
//   flush_id, flush_ex  bubble into IF/ID, bubble into ID/EX
//   state               debug encoding RUN=0, FLUSH=1, DWAIT=2
//   stall_cycles        saturating count of cycles with hazard=1
//   mem_err             sticky dmem timeout flag
module pipeline_hazard_ctrl #(
  parameter int unsigned REGW         = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNTW         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [REGW-1:0] ex_rt,
  input  logic            ex_branch_taken,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            pcsrc,
  output logic            hazard,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            flush_id,
  output logic            flush_ex,
  output logic [1:0]      state,
  output logic [CNTW-1:0] stall_cycles,
  output logic            mem_err
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DWAIT = 2'd2;

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(TIMEOUT);
  // Remaining flush cycles after the branch-resolution cycle itself.
  localparam logic [3:0] FINIT = 4'(FLUSH_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [CNTW-1:0] stall_q;
  logic            err_q, err_d;
  logic            lu;

  // A load into $zero never creates a real dependency.
  assign lu = ex_memread && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pcsrc    = 1'b0;
    hazard   = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;

    if (reset) begin
      // Controls stay low; registers are cleared in the sequential block.
    end else if (!dmem_ready) begin
      // Freeze everything; a pending branch or flush resumes afterwards.
      hazard   = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      wcnt_d   = (wcnt_q == WMAX) ? WMAX : wcnt_q + 1'b1;
      if (wcnt_d == WMAX) begin
        err_d = 1'b1;
      end
      if (state_q != FLUSH) begin
        state_d = DWAIT;
      end
    end else begin
      wcnt_d = '0;
      if (state_q == FLUSH) begin
        // Wrong-path instructions: branch and load-use inputs are ignored.
        flush_id = 1'b1;
        hazard   = !imem_ready;
        fcnt_d   = fcnt_q - 4'd1;
        if (fcnt_q == 4'd1) begin
          state_d = RUN;
        end
      end else begin
        // RUN, or DWAIT whose access just completed: same-cycle RUN rules.
        state_d = RUN;
        if (ex_branch_taken) begin
          pcsrc    = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FINIT;
          end
        end else if (lu) begin
          hazard   = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end else if (!imem_ready) begin
          hazard   = 1'b1;
          flush_id = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      if (hazard && (stall_q != {CNTW{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FC = 3;
  localparam int unsigned TO = 4;
  localparam longint unsigned MAXC = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic        imem_ready = 1'b1, dmem_ready = 1'b1;
  logic        pcsrc, hazard, stall_id, stall_ex, flush_id, flush_ex, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass = 0;

  pipeline_hazard_ctrl #(
    .REGW(5), .FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNTW(32)
  ) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pcsrc(pcsrc), .hazard(hazard),
    .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id), .flush_ex(flush_ex),
    .state(state), .stall_cycles(stall_cycles), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: remaining flush cycles, consecutive dmem wait count,
  // sticky error and stall count, kept as plain integers.
  int flush_left = 0;
  int wait_cnt = 0;
  bit err_m = 0;
  longint unsigned stalls_m = 0;
  bit model_valid = 0;

  always @(negedge clk) begin
    bit lu_m;
    bit e_pc, e_hz, e_sid, e_sex, e_fid, e_fex;
    int e_state;
    lu_m = ex_memread && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    {e_pc, e_hz, e_sid, e_sex, e_fid, e_fex} = '0;
    if (reset) begin
      // all controls low
    end else if (!dmem_ready) begin
      {e_hz, e_sid, e_sex} = 3'b111;
    end else if (flush_left > 0) begin
      e_fid = 1;
      e_hz  = !imem_ready;
    end else if (ex_branch_taken) begin
      {e_pc, e_fid, e_fex} = 3'b111;
    end else if (lu_m) begin
      {e_hz, e_sid, e_fex} = 3'b111;
    end else if (!imem_ready) begin
      {e_hz, e_fid} = 2'b11;
    end
    e_state = (flush_left > 0) ? 1 : (wait_cnt > 0) ? 2 : 0;

    if (model_valid) begin
      chk("pcsrc", 64'(pcsrc), 64'(e_pc));
      chk("hazard", 64'(hazard), 64'(e_hz));
      chk("stall_id", 64'(stall_id), 64'(e_sid));
      chk("stall_ex", 64'(stall_ex), 64'(e_sex));
      chk("flush_id", 64'(flush_id), 64'(e_fid));
      chk("flush_ex", 64'(flush_ex), 64'(e_fex));
      chk("state", 64'(state), 64'(e_state));
      chk("stall_cycles", 64'(stall_cycles), stalls_m);
      chk("mem_err", 64'(mem_err), 64'(err_m));
    end

    if (reset) begin
      flush_left = 0; wait_cnt = 0; err_m = 0; stalls_m = 0; model_valid = 1;
    end else begin
      if (e_hz && stalls_m != MAXC) stalls_m++;
      if (!dmem_ready) begin
        wait_cnt = (wait_cnt < TO) ? wait_cnt + 1 : TO;
        if (wait_cnt == TO) err_m = 1;
      end else begin
        wait_cnt = 0;
        if (flush_left > 0) flush_left--;
        else if (ex_branch_taken && FC > 1) flush_left = FC - 1;
      end
    end
  end

  task automatic apply(input logic rst, input logic br, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic im, input logic dm);
    @(posedge clk);
    #1;
    reset = rst; ex_branch_taken = br; ex_memread = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; imem_ready = im; dmem_ready = dm;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("reset state", 64'(state), 0);
    chk("reset stall_cycles", 64'(stall_cycles), 0);
    chk("reset mem_err", 64'(mem_err), 0);
    chk("reset hazard", 64'(hazard), 0);

    // Load-use on rs.
    apply(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1);
    chk("lu hazard", 64'(hazard), 1);
    chk("lu stall_id", 64'(stall_id), 1);
    chk("lu flush_ex", 64'(flush_ex), 1);
    chk("lu stall_ex", 64'(stall_ex), 0);
    idle();
    chk("lu count", 64'(stall_cycles), 1);
    chk("lu one cycle", 64'(hazard), 0);
    // Load into $zero is not a hazard.
    apply(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1);
    chk("lu r0 hazard", 64'(hazard), 0);

    // Taken branch, three flush cycles, second branch ignored.
    apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("br pcsrc", 64'(pcsrc), 1);
    chk("br flush_id", 64'(flush_id), 1);
    chk("br flush_ex", 64'(flush_ex), 1);
    apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("br c1 state", 64'(state), 1);
    chk("br c1 pcsrc ignored", 64'(pcsrc), 0);
    chk("br c1 flush_id", 64'(flush_id), 1);
    idle();
    chk("br c2 state", 64'(state), 1);
    idle();
    chk("br c3 state", 64'(state), 0);
    chk("br c3 flush_id", 64'(flush_id), 0);

    // Dmem wait with a branch held in EX.
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 1, 0);
      chk("dwait pcsrc", 64'(pcsrc), 0);
      chk("dwait stall_ex", 64'(stall_ex), 1);
    end
    apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("dwait release pcsrc", 64'(pcsrc), 1);
    chk("dwait release state", 64'(state), 2);
    chk("dwait stall count", 64'(stall_cycles), 6);
    chk("dwait mem_err", 64'(mem_err), 1);
    idle(); idle(); idle();
    chk("dwait flush done", 64'(state), 0);
    do_reset();
    idle();
    chk("reset clears mem_err", 64'(mem_err), 0);

    // Timeout with TIMEOUT=4.
    for (int i = 1; i <= 10; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 4) chk("timeout not yet", 64'(mem_err), 0);
      if (i == 5) chk("timeout set", 64'(mem_err), 1);
    end
    idle(); idle();
    chk("timeout sticky", 64'(mem_err), 1);
    chk("timeout back to run", 64'(state), 0);
    do_reset();
    idle();
    chk("timeout cleared", 64'(mem_err), 0);

    // Imem miss mid-flush does not extend the flush.
    apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("imiss hazard", 64'(hazard), 1);
    chk("imiss flush_id", 64'(flush_id), 1);
    idle();
    chk("imiss c2 state", 64'(state), 1);
    idle();
    chk("imiss c3 state", 64'(state), 0);

    // Reset in the middle of a flush.
    apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
    apply(1, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("rst mid pcsrc", 64'(pcsrc), 0);
    chk("rst mid flush_id", 64'(flush_id), 0);
    idle();
    chk("rst mid state", 64'(state), 0);
    chk("rst mid stall_cycles", 64'(stall_cycles), 0);
    chk("rst mid flush_id after", 64'(flush_id), 0);

    // Randomized traffic, register indices kept small to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 40),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 80));
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
